// File: rtl/booking_pkg.sv
// booking_pkg: shared state enum, station/ticket limits, widths and request validity check
// Station codes: train 0 Chennai..Bengaluru = 0..4, train 1 New Delhi..Varanasi = 0..3.
package booking_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   localparam int ST_W   = 3;
   localparam int TK_W   = 4;
   localparam int FARE_W = 10;
   localparam int RF_W   = 16;
   localparam logic [ST_W-1:0] MAX_STATION_T0 = 3'd4;
   localparam logic [ST_W-1:0] MAX_STATION_T1 = 3'd3;
   localparam logic [TK_W-1:0] MAX_TICKETS    = 4'd10;
   function automatic logic req_bad(logic train, logic [ST_W-1:0] src, logic [ST_W-1:0] dest,
                                    logic [TK_W-1:0] tk);
      return (src >= dest) || (dest > (train ? MAX_STATION_T1 : MAX_STATION_T0)) ||
             (tk == '0) || (tk > MAX_TICKETS);
   endfunction
endpackage

// File: rtl/booking_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req_i bit at or after ptr_i (wrapping)
// Ports: req_i request vector, ptr_i priority pointer, gnt_o one-hot grant, idx_o grant index,
//        any_o at least one request.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] idx_o,
   output logic                 any_o
);
   localparam int IW = $clog2(N);
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = |req_i;
      // scan from the farthest offset back so the nearest one to ptr_i wins
      for (int i = N - 1; i >= 0; i--)
         if (req_i[(int'(ptr_i) + i) % N]) idx_o = IW'((int'(ptr_i) + i) % N);
      gnt_o[idx_o] = any_o;
   end
endmodule

// File: rtl/booking_arbiter.sv
// booking_arbiter: round-robin share of one reservation core among NUM_REQ booking counters
// Ports: req_* per-counter request channel (valid/ready, train, src, dest, tickets);
//        core_* booking strobe + latched fields out, core results in;
//        resp_* one-hot result strobe and shared result bus; stat_* statistics.
// Macro BOOKING_ARB_STATS_EN enables the saturating grant/reject counters, else they read 0.
module booking_arbiter import booking_pkg::*; #(
   parameter int NUM_REQ   = 4,
   parameter int RESP_WAIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ-1:0]    req_train,
   input  logic [3*NUM_REQ-1:0]  req_src,
   input  logic [3*NUM_REQ-1:0]  req_dest,
   input  logic [4*NUM_REQ-1:0]  req_tickets,
   output logic                  core_book_req,
   output logic                  core_train_id,
   output logic [ST_W-1:0]       core_src,
   output logic [ST_W-1:0]       core_dest,
   output logic [TK_W-1:0]       core_num_tickets,
   input  logic                  core_success,
   input  logic [TK_W-1:0]       core_booked_count,
   input  logic [FARE_W-1:0]     core_fare,
   output logic [NUM_REQ-1:0]    resp_valid,
   output logic                  resp_success,
   output logic [TK_W-1:0]       resp_count,
   output logic [RF_W-1:0]       resp_fare,
   output logic [15:0]           stat_grants,
   output logic [15:0]           stat_rejects
);
   localparam int IW = $clog2(NUM_REQ);
   state_t          state_q;
   logic [IW-1:0]   rr_q, gidx_q, pidx;
   logic [NUM_REQ-1:0] pgnt;
   logic            pany;
   logic [3:0]      wcnt_q;
   logic            sel_train;
   logic [ST_W-1:0] sel_src, sel_dest;
   logic [TK_W-1:0] sel_tk;
   rr_pick #(.N(NUM_REQ)) u_pick (
      .req_i (req_valid),
      .ptr_i (rr_q),
      .gnt_o (pgnt),
      .idx_o (pidx),
      .any_o (pany)
   );
   assign req_ready = (state_q == IDLE) ? pgnt : '0;
   assign sel_train = req_train[pidx];
   assign sel_src   = req_src[int'(pidx)*3 +: 3];
   assign sel_dest  = req_dest[int'(pidx)*3 +: 3];
   assign sel_tk    = req_tickets[int'(pidx)*4 +: 4];
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         rr_q             <= '0;
         gidx_q           <= '0;
         wcnt_q           <= '0;
         core_book_req    <= 1'b0;
         core_train_id    <= 1'b0;
         core_src         <= '0;
         core_dest        <= '0;
         core_num_tickets <= '0;
         resp_valid       <= '0;
         resp_success     <= 1'b0;
         resp_count       <= '0;
         resp_fare        <= '0;
      end else begin
         core_book_req <= 1'b0;
         resp_valid    <= '0;
         case (state_q)
            IDLE: if (pany) begin
               gidx_q           <= pidx;
               core_train_id    <= sel_train;
               core_src         <= sel_src;
               core_dest        <= sel_dest;
               core_num_tickets <= sel_tk;
               if (req_bad(sel_train, sel_src, sel_dest, sel_tk)) begin
                  state_q      <= RESP;
                  resp_valid   <= pgnt;
                  resp_success <= 1'b0;
                  resp_count   <= '0;
                  resp_fare    <= '0;
               end else begin
                  state_q       <= ISSUE;
                  core_book_req <= 1'b1;
               end
            end
            ISSUE: begin
               state_q <= WAIT;
               wcnt_q  <= 4'(RESP_WAIT - 1);
            end
            WAIT: if (wcnt_q == '0) begin
               state_q      <= RESP;
               resp_valid   <= NUM_REQ'(1) << gidx_q;
               resp_success <= core_success;
               resp_count   <= core_success ? core_booked_count : '0;
               resp_fare    <= core_success ? RF_W'(core_fare) * RF_W'(core_booked_count) : '0;
            end else begin
               wcnt_q <= wcnt_q - 4'd1;
            end
            RESP: begin
               state_q <= IDLE;
               rr_q    <= (int'(gidx_q) == NUM_REQ - 1) ? '0 : gidx_q + IW'(1);
            end
         endcase
      end
   end
`ifdef BOOKING_ARB_STATS_EN
   // resp_success already folds local rejects and core failures into a single 0
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_grants  <= '0;
         stat_rejects <= '0;
      end else if (state_q == RESP) begin
         if (resp_success && stat_grants != 16'hFFFF) stat_grants <= stat_grants + 16'd1;
         if (!resp_success && stat_rejects != 16'hFFFF) stat_rejects <= stat_rejects + 16'd1;
      end
   end
`else
   assign stat_grants  = '0;
   assign stat_rejects = '0;
`endif
endmodule

// File: tb/tb_booking_arbiter.sv
// tb_booking_arbiter: directed + randomized checks of booking_arbiter against a transaction model
module tb_booking_arbiter;
   localparam int N  = 4;
   localparam int RW = 4;
`ifdef BOOKING_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst;
   logic [N-1:0] req_valid, req_ready, req_train, resp_valid;
   logic [3*N-1:0] req_src, req_dest;
   logic [4*N-1:0] req_tickets;
   logic core_book_req, core_train_id, core_success, resp_success;
   logic [2:0] core_src, core_dest;
   logic [3:0] core_num_tickets, core_booked_count, resp_count;
   logic [9:0] core_fare;
   logic [15:0] resp_fare, stat_grants, stat_rejects;
   int errors = 0, checks = 0, rr_m = 0, gr_m = 0, rej_m = 0, g;
   time t_acc, t_prev;
   always #5 clk = ~clk;
   booking_arbiter #(.NUM_REQ(N), .RESP_WAIT(RW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_train(req_train),
      .req_src(req_src), .req_dest(req_dest), .req_tickets(req_tickets),
      .core_book_req(core_book_req), .core_train_id(core_train_id), .core_src(core_src),
      .core_dest(core_dest), .core_num_tickets(core_num_tickets), .core_success(core_success),
      .core_booked_count(core_booked_count), .core_fare(core_fare), .resp_valid(resp_valid),
      .resp_success(resp_success), .resp_count(resp_count), .resp_fare(resp_fare),
      .stat_grants(stat_grants), .stat_rejects(stat_rejects)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic set_req(input int k, input int t, input int s, input int d, input int n);
      req_train[k]       = 1'(t);
      req_src[3*k +: 3]  = 3'(s);
      req_dest[3*k +: 3] = 3'(d);
      req_tickets[4*k +: 4] = 4'(n);
   endtask
   task automatic rand_req(input int k);
      int t, mx, s, d, n;
      t  = $urandom_range(0, 1);
      mx = t ? 3 : 4;
      if ($urandom_range(0, 9) < 7) begin
         s = $urandom_range(0, mx - 1);
         d = $urandom_range(s + 1, mx);
         n = $urandom_range(1, 10);
      end else begin
         s = $urandom_range(0, 7);
         d = $urandom_range(0, 7);
         n = $urandom_range(0, 15);
      end
      set_req(k, t, s, d, n);
   endtask
   task automatic set_core(input int s, input int c, input int f);
      core_success      = 1'(s);
      core_booked_count = 4'(c);
      core_fare         = 10'(f);
   endtask
   task automatic chk_stats(input string tag);
      chk({tag, "_grants"}, 32'(stat_grants), STATS ? 32'(gr_m) : 32'd0);
      chk({tag, "_rejects"}, 32'(stat_rejects), STATS ? 32'(rej_m) : 32'd0);
   endtask
   // One transaction from the model's point of view: the model picks the grantee by the
   // round-robin rule, judges validity from the booking rules and predicts every cycle.
   task automatic run_txn(output int g_o);
      int gg, t, s, d, n, mx;
      logic [N-1:0] oh;
      logic [31:0] fexp;
      bit bad;
      #1;
      gg = 0;
      for (int o = N - 1; o >= 0; o--) if (req_valid[(rr_m + o) % N]) gg = (rr_m + o) % N;
      oh = N'(1) << gg;
      chk("req_ready", 32'(req_ready), 32'(oh));
      @(posedge clk);
      t_acc = $time;
      @(negedge clk);
      req_valid[gg] = 1'b0;
      t  = int'(req_train[gg]);
      s  = int'(req_src[3*gg +: 3]);
      d  = int'(req_dest[3*gg +: 3]);
      n  = int'(req_tickets[4*gg +: 4]);
      mx = t ? 3 : 4;
      bad = s >= d || d > mx || n == 0 || n > 10;
      if (bad) begin
         chk("rej_no_book", 32'(core_book_req), 0);
         chk("rej_resp_valid", 32'(resp_valid), 32'(oh));
         chk("rej_resp_bus", {resp_success, resp_count, resp_fare}, 0);
         rej_m++;
         @(negedge clk);
         chk("rej_resp_done", 32'(resp_valid), 0);
      end else begin
         chk("book_pulse", 32'(core_book_req), 1);
         chk("core_fields", {core_train_id, core_src, core_dest, core_num_tickets},
             32'((t << 10) | (s << 7) | (d << 4) | n));
         for (int c = 1; c <= RW; c++) begin
            @(negedge clk);
            chk("wait_quiet", {core_book_req, resp_valid}, 0);
         end
         @(negedge clk);
         fexp = core_success ? 32'(core_fare) * 32'(core_booked_count) : 0;
         chk("resp_valid", 32'(resp_valid), 32'(oh));
         chk("resp_success", 32'(resp_success), 32'(core_success));
         chk("resp_count", 32'(resp_count), core_success ? 32'(core_booked_count) : 0);
         chk("resp_fare", 32'(resp_fare), fexp);
         if (core_success) gr_m++; else rej_m++;
         @(negedge clk);
         chk("resp_done", 32'(resp_valid), 0);
      end
      rr_m = (gg + 1) % N;
      g_o = gg;
   endtask
   initial begin
      rst = 1'b1;
      req_valid = '0; req_train = '0; req_src = '0; req_dest = '0; req_tickets = '0;
      set_core(0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ready_valid", {req_ready, resp_valid, core_book_req}, 0);
      chk("rst_core_fields", {core_train_id, core_src, core_dest, core_num_tickets}, 0);
      chk("rst_resp_bus", {resp_success, resp_count, resp_fare}, 0);
      chk_stats("rst_stats");
      @(negedge clk);
      // single request: 2 tickets at fare 50 -> 100
      set_req(0, 0, 0, 1, 2);
      set_core(1, 2, 50);
      req_valid = 4'b0001;
      run_txn(g);
      // local reject from counter 3 (src == dest), moves pointer back to 0
      set_req(3, 1, 2, 2, 3);
      req_valid = 4'b1000;
      run_txn(g);
      // contention among 1, 2, 3
      set_core(1, 3, 120);
      for (int k = 1; k < N; k++) set_req(k, k % 2, 0, 2, k);
      req_valid = 4'b1110;
      for (int k = 0; k < 3; k++) begin
         t_prev = t_acc;
         run_txn(g);
         if (k > 0) chk("contention_spacing", 32'(t_acc - t_prev), 32'(10 * (RW + 3)));
      end
      // over-capacity: 12 tickets
      set_req(0, 0, 0, 3, 12);
      req_valid = 4'b0001;
      run_txn(g);
      chk_stats("overcap_stats");
      // core failure
      set_req(1, 0, 1, 4, 3);
      set_core(0, 3, 80);
      req_valid = 4'b0010;
      run_txn(g);
      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         for (int k = 0; k < N; k++) rand_req(k);
         set_core($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1023));
         req_valid = N'($urandom_range(1, (1 << N) - 1));
         run_txn(g);
         req_valid = '0;
      end
      chk_stats("random_stats");
      // reset while waiting on the core
      set_req(0, 0, 0, 1, 2);
      set_core(1, 2, 50);
      req_valid = 4'b0001;
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      rr_m = 0; gr_m = 0; rej_m = 0;
      #1;
      chk("mid_rst_outputs", {req_ready, resp_valid, core_book_req}, 0);
      chk("mid_rst_core_fields", {core_train_id, core_src, core_dest, core_num_tickets}, 0);
      chk("mid_rst_resp_bus", {resp_success, resp_count, resp_fare}, 0);
      chk_stats("mid_rst_stats");
      begin
         logic [N-1:0] seen;
         seen = '0;
         for (int c = 0; c < RW + 3; c++) begin
            @(negedge clk);
            seen |= resp_valid;
         end
         chk("mid_rst_no_resp", 32'(seen), 0);
      end
      set_req(2, 0, 1, 3, 4);
      set_req(3, 1, 0, 3, 1);
      set_core(1, 4, 200);
      req_valid = 4'b1100;
      run_txn(g);
      run_txn(g);
      chk_stats("final_stats");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
